// File: rtl/paillier_op_scheduler_if.sv
// Command, datapath-control and response signals of the Paillier op scheduler.
// slave: the scheduler side. master: host plus datapath side.
interface paillier_op_scheduler_if #(
  parameter int unsigned RSA_WIDTH = 4096,
  parameter int unsigned TAG_WIDTH = 4
);
  localparam int unsigned OP_WIDTH = 4;

  // Host command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_WIDTH-1:0]  cmd_op;
  logic [TAG_WIDTH-1:0] cmd_tag;

  // Datapath control
  logic [OP_WIDTH-1:0]  core_state;
  logic                 core_go;
  logic [TAG_WIDTH-1:0] cur_tag;
  logic                 core_done;
  logic [RSA_WIDTH-1:0] core_result;

  // Response channel and status
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [RSA_WIDTH-1:0] rsp_result;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_tag, core_done, core_result, rsp_ready,
    output cmd_ready, core_state, core_go, cur_tag,
           rsp_valid, rsp_tag, rsp_result, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_tag, core_done, core_result, rsp_ready,
    input  cmd_ready, core_state, core_go, cur_tag,
           rsp_valid, rsp_tag, rsp_result, rsp_err, busy
  );
endinterface

// File: rtl/paillier_op_scheduler.sv
// Paillier op scheduler: queues opcode/tag commands in a small FIFO, sequences
// the datapath one operation at a time (SETUP -> go pulse -> WAIT for done) and
// returns the result on a valid/ready response port.
// Optional watchdog on the WAIT state: define PAILLIER_SCHED_TIMEOUT_EN.
module paillier_op_scheduler #(
  parameter int unsigned RSA_WIDTH     = 4096,
  parameter int unsigned TAG_WIDTH     = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  paillier_op_scheduler_if.slave bus
);
  localparam int unsigned OP_WIDTH  = 4;
  localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  // Elaboration guard on parameter ranges
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_WIDTH < 2)) begin : g_param_chk
    $error("paillier_op_scheduler: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_WIDTH >= 2");
  end

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [TAG_WIDTH-1:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // Legal opcodes are exactly one-hot
  function automatic logic is_onehot(input logic [OP_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - OP_WIDTH'(1))) == '0);
  endfunction

  state_e               state_q, state_d;
  cmd_t                 mem_q [FIFO_DEPTH];
  cmd_t                 cmd_in, head;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push, pop;

  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic [OP_WIDTH-1:0]  core_state_q, core_state_d;
  logic                 core_go_q, core_go_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [RSA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 wd_expired;

  assign cmd_in = cmd_t'{op: bus.cmd_op, tag: bus.cmd_tag};
  assign head   = mem_q[rd_ptr_q];
  assign push   = bus.cmd_valid && cmd_ready_q;

`ifdef PAILLIER_SCHED_TIMEOUT_EN
  // Last WAIT cycle before timeout: counter value 2^W-2 means this is WAIT cycle 2^W-1
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [TIMEOUT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog next value: cleared while issuing, counts each WAIT cycle
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == S_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_expired = (wd_cnt_q == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Next state, command capture, response capture and next output values
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    op_d         = op_q;
    tag_d        = tag_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          op_d  = head.op;
          tag_d = head.tag;
          if (is_onehot(head.op)) begin
            state_d = S_SETUP;
          end else begin
            state_d      = S_RESP;
            rsp_tag_d    = head.tag;
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
          end
        end
      end
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A done coinciding with the timeout still delivers the real result
        if (bus.core_done) begin
          state_d      = S_RESP;
          rsp_tag_d    = tag_q;
          rsp_result_d = bus.core_result;
          rsp_err_d    = 1'b0;
        end else if (wd_expired) begin
          state_d      = S_RESP;
          rsp_tag_d    = tag_q;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    core_state_d = '0;
    if ((state_d == S_SETUP) || (state_d == S_ISSUE) || (state_d == S_WAIT)) begin
      core_state_d = op_d;
    end
    core_go_d   = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
    cmd_ready_d = (count_d != CNT_WIDTH'(FIFO_DEPTH));
  end

  // State, FIFO control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      cmd_ready_q  <= 1'b0;
      core_state_q <= '0;
      core_go_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      cmd_ready_q  <= cmd_ready_d;
      core_state_q <= core_state_d;
      core_go_q    <= core_go_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.core_state = core_state_q;
  assign bus.core_go    = core_go_q;
  assign bus.cur_tag    = tag_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;

endmodule
